// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: region bounds, grant source
// encoding and the data-access legality check.
package mem_arb_pkg;

    localparam logic [31:0] IMEM_LIMIT_DEF = 32'h0000_0800;
    localparam logic [31:0] MEM_TOP_DEF    = 32'h0000_1000;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } gnt_src_t;

    // Misaligned, out of memory, or a store into the instruction region.
    function automatic logic d_access_err(
        input logic [31:0] addr,
        input logic        we,
        input logic [31:0] imem_limit,
        input logic [31:0] mem_top
    );
        return (addr[1:0] != 2'b00) || (addr >= mem_top) || (we && (addr < imem_limit));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; last_d remembers whether data won the last grant.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     req_if,
    input  logic     req_d,
    output gnt_src_t gnt_src
);

    logic last_d;

    always_comb begin
        // NOTE: default assigned first so every path drives gnt_src and no latch is inferred.
        gnt_src = GNT_NONE;
        if (!reset) begin
            if (req_if && (!req_d || last_d)) begin
                gnt_src = GNT_IF;
            end else if (req_d) begin
                gnt_src = GNT_D;
            end
        end
    end

    // Reset to 1 so the first contention after reset goes to fetch.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state to avoid ordering races.
        if (reset) begin
            last_d <= 1'b1;
        end else begin
            case (gnt_src)
                GNT_D:   last_d <= 1'b1;
                GNT_IF:  last_d <= 1'b0;
                default: last_d <= last_d;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational-read memory between fetch and load/store: one grant per
// cycle, round-robin under contention, registered one-cycle responses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] IMEM_LIMIT = IMEM_LIMIT_DEF,
    parameter logic [31:0] MEM_TOP    = MEM_TOP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_we
);

    gnt_src_t gnt_src;
    logic     d_bad;
    logic     if_rvalid_q;
    logic     d_rvalid_q;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req_if  (if_req),
        .req_d   (d_req),
        .gnt_src (gnt_src)
    );

    assign if_gnt      = (gnt_src == GNT_IF);
    assign d_gnt       = (gnt_src == GNT_D);
    assign d_bad       = d_access_err(d_addr, d_we, IMEM_LIMIT, MEM_TOP);
    assign mem_data_in = d_wdata;
    assign mem_we      = d_gnt && d_we && !d_bad;

    always_comb begin
        mem_address = 32'h0;
        case (gnt_src)
            GNT_IF:  mem_address = if_addr;
            GNT_D:   mem_address = d_addr;
            default: mem_address = 32'h0;
        endcase
    end

    // Responses launched just before reset asserts must not be seen by the core.
    assign if_rvalid = if_rvalid_q && !reset;
    assign d_rvalid  = d_rvalid_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_rvalid_q <= 1'b0;
            if_rdata    <= 32'h0;
            d_rvalid_q  <= 1'b0;
            d_rdata     <= 32'h0;
            d_err       <= 1'b0;
        end else begin
            if_rvalid_q <= if_gnt;
            d_rvalid_q  <= d_gnt;
            if (if_gnt) begin
                if_rdata <= mem_data_out;
            end
            if (d_gnt) begin
                d_rdata <= (d_we || d_bad) ? 32'h0 : mem_data_out;
                d_err   <= d_bad;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses, a monitor pops and compares.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_we;

    logic [31:0] mem [0:4095];

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       if_q[$];
    resp_t       d_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [31:0] W_BEEF = 32'hDEAD_BEEF;
    localparam logic [31:0] W_0    = 32'h1111_0000;
    localparam logic [31:0] W_4    = 32'h1111_0004;
    localparam logic [31:0] W_8    = 32'h1111_0008;
    localparam logic [31:0] W_100  = 32'hAAAA_0100;
    localparam logic [31:0] W_1000 = 32'hBBBB_1000;
    localparam logic [31:0] W_A00  = 32'hCAFE_0A00;

    mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write at the clock edge, aliased by address[13:2].
    assign mem_data_out = mem[mem_address[13:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_address[13:2]] <= mem_data_in;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle, a response is expected exactly when the queue head is due.
    resp_t if_r, d_r;
    logic  if_exp_v, d_exp_v;
    always @(negedge clk) begin
        if_exp_v = (if_q.size() > 0) && (if_q[0].cyc == cyc);
        check("if_rvalid", 32'(if_rvalid), 32'(if_exp_v));
        if (if_exp_v) begin
            if_r = if_q.pop_front();
            if (if_rvalid) check("if_rdata", if_rdata, if_r.rdata);
        end
        d_exp_v = (d_q.size() > 0) && (d_q[0].cyc == cyc);
        check("d_rvalid", 32'(d_rvalid), 32'(d_exp_v));
        if (d_exp_v) begin
            d_r = d_q.pop_front();
            if (d_rvalid) begin
                check("d_rdata", d_rdata, d_r.rdata);
                check("d_err", 32'(d_err), 32'(d_r.err));
            end
        end
    end

    // One cycle: drive at posedge+1, check grant-cycle outputs at negedge, queue the response.
    task automatic step(
        input logic rst,
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic eig, input logic edg, input logic ewe, input logic [31:0] eaddr,
        input logic [31:0] erd, input logic eerr, input logic push
    );
        resp_t r;
        reset = rst; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        @(negedge clk);
        check("if_gnt", 32'(if_gnt), 32'(eig));
        check("d_gnt", 32'(d_gnt), 32'(edg));
        check("mem_we", 32'(mem_we), 32'(ewe));
        check("mem_address", mem_address, eaddr);
        check("mem_data_in", mem_data_in, dd);
        if (push) begin
            r.cyc = cyc + 1; r.rdata = erd; r.err = eerr;
            if (eig) if_q.push_back(r);
            if (edg) d_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0] = W_0; mem[1] = W_4; mem[2] = W_8; mem[4] = W_BEEF;
        mem[12'h040] = W_100; mem[12'h280] = W_A00; mem[12'h400] = W_1000;
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        @(posedge clk);
        #1;
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_d_err", 32'(d_err), 32'h0);

        // Requests during reset are not granted.
        step(1, 1, 32'h10, 1, 0, 32'hA00, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        step(1, 1, 32'h10, 1, 1, 32'h900, 32'h5, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Fetch, store, then load of the just-stored word.
        step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h10, W_BEEF, 0, 1);
        step(0, 0, 32'h0, 1, 1, 32'h900, 32'h1234, 0, 1, 1, 32'h900, 32'h0, 0, 1);
        step(0, 0, 32'h0, 1, 0, 32'h900, 32'h0, 0, 1, 0, 32'h900, 32'h1234, 0, 1);

        // Continuous contention: F, D, F, D, F, D.
        step(0, 1, 32'h0, 1, 0, 32'hA00, 32'h0, 1, 0, 0, 32'h0, W_0, 0, 1);
        step(0, 1, 32'h4, 1, 0, 32'hA00, 32'h0, 0, 1, 0, 32'hA00, W_A00, 0, 1);
        step(0, 1, 32'h4, 1, 0, 32'hA00, 32'h0, 1, 0, 0, 32'h4, W_4, 0, 1);
        step(0, 1, 32'h8, 1, 0, 32'hA00, 32'h0, 0, 1, 0, 32'hA00, W_A00, 0, 1);
        step(0, 1, 32'h8, 1, 0, 32'hA00, 32'h0, 1, 0, 0, 32'h8, W_8, 0, 1);
        step(0, 1, 32'h0, 1, 0, 32'hA00, 32'h0, 0, 1, 0, 32'hA00, W_A00, 0, 1);

        // Illegal stores: imem region, misaligned, past the top.
        step(0, 0, 32'h0, 1, 1, 32'h100, 32'hFFFF_FFFF, 0, 1, 0, 32'h100, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1, 32'h902, 32'hFFFF_FFFF, 0, 1, 0, 32'h902, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1, 32'h1000, 32'hFFFF_FFFF, 0, 1, 0, 32'h1000, 32'h0, 1, 1);
        // Memory must be untouched by the rejected stores.
        step(0, 1, 32'h100, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h100, W_100, 0, 1);
        step(0, 1, 32'h900, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h900, 32'h1234, 0, 1);
        step(0, 1, 32'h1000, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h1000, W_1000, 0, 1);

        // Load granted, reset next cycle drops its response; first contention then goes to fetch.
        step(0, 0, 32'h0, 1, 0, 32'hA00, 32'h0, 0, 1, 0, 32'hA00, 32'h0, 0, 0);
        step(1, 0, 32'h0, 1, 0, 32'hA00, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        step(1, 1, 32'h10, 1, 1, 32'h900, 32'h7, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 1, 32'h10, 1, 0, 32'hA00, 32'h0, 1, 0, 0, 32'h10, W_BEEF, 0, 1);
        step(0, 0, 32'h0, 1, 0, 32'hA00, 32'h0, 0, 1, 0, 32'hA00, W_A00, 0, 1);

        // Fetch alone, back to back.
        step(0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0, W_0, 0, 1);
        step(0, 1, 32'h4, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h4, W_4, 0, 1);
        step(0, 1, 32'h8, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h8, W_8, 0, 1);

        // Idle drains the last response.
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        check("if_q_drained", 32'(if_q.size()), 32'h0);
        check("d_q_drained", 32'(d_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
